// File: rtl/wb_mem_slave.sv
// Pipelined Wishbone B4 memory slave: DEPTH x DW storage, byte-select writes, LATENCY-cycle responses.
// Optional window decode with err responses is enabled by defining WB_MEM_SLAVE_ERR_EN.
module wb_mem_slave #(
  parameter int DW        = 32,
  parameter int AW        = 30,
  parameter int DEPTH     = 8,
  parameter int BASE_ADDR = 0,
  parameter int LATENCY   = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic [AW-1:0]   i_wb_addr,
  input  logic [DW-1:0]   i_wb_data,
  input  logic [DW/8-1:0] i_wb_sel,
  output logic            o_wb_stall,
  output logic            o_wb_ack,
  output logic            o_wb_err,
  output logic [DW-1:0]   o_wb_data,
  output logic [7:0]      o_leds
);

  localparam int IW = $clog2(DEPTH);
  localparam int SW = DW / 8;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state;
  logic [IW-1:0] init_idx;
  logic [DW-1:0] mem [DEPTH];

  logic          accept;
  logic          in_range;
  logic [IW-1:0] index;
  logic          req_ack;
  logic          req_err;
  logic          req_rd;
  logic [DW-1:0] req_data;

  logic          fin_ack;
  logic          fin_err;
  logic          fin_rd;
  logic [DW-1:0] fin_data;

  // Handshake: a request transfers on any edge where cyc & stb are high and stall is low;
  // every transferred request gets exactly one ack or err pulse LATENCY cycles later, in order,
  // unless cyc drops or reset hits first, in which case all in-flight responses are discarded.
  assign accept = i_wb_cyc && i_wb_stb && !o_wb_stall;

`ifdef WB_MEM_SLAVE_ERR_EN
  logic [AW-1:0] offset;
  // Unsigned wrap makes addresses below the base land far above DEPTH.
  assign offset   = i_wb_addr - AW'(BASE_ADDR);
  assign in_range = offset < AW'(DEPTH);
  assign index    = offset[IW-1:0];
`else
  logic unused_addr;
  assign unused_addr = ^i_wb_addr[AW-1:IW];
  assign in_range    = 1'b1;
  assign index       = i_wb_addr[IW-1:0];
`endif

  assign req_ack  = accept && in_range;
  assign req_err  = accept && !in_range;
  assign req_rd   = accept && in_range && !i_wb_we;
  assign req_data = mem[index];

  generate
    if (LATENCY == 1) begin : g_direct
      assign fin_ack  = req_ack;
      assign fin_err  = req_err;
      assign fin_rd   = req_rd;
      assign fin_data = req_data;
    end else begin : g_pipe
      logic [LATENCY-2:0] p_ack;
      logic [LATENCY-2:0] p_err;
      logic [LATENCY-2:0] p_rd;
      logic [DW-1:0]      p_data [LATENCY-1];

      always_ff @(posedge i_clk) begin
        if (i_rst || !i_wb_cyc) begin
          p_ack <= '0;
          p_err <= '0;
          p_rd  <= '0;
        end else begin
          p_ack[0] <= req_ack;
          p_err[0] <= req_err;
          p_rd[0]  <= req_rd;
          for (int i = 1; i < LATENCY - 1; i++) begin
            p_ack[i] <= p_ack[i-1];
            p_err[i] <= p_err[i-1];
            p_rd[i]  <= p_rd[i-1];
          end
        end
      end

      // Read data travels alongside its flags; the flags alone decide whether it is used.
      always_ff @(posedge i_clk) begin
        p_data[0] <= req_data;
        for (int i = 1; i < LATENCY - 1; i++) begin
          p_data[i] <= p_data[i-1];
        end
      end

      assign fin_ack  = p_ack[LATENCY-2];
      assign fin_err  = p_err[LATENCY-2];
      assign fin_rd   = p_rd[LATENCY-2];
      assign fin_data = p_data[LATENCY-2];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_INIT;
      init_idx   <= '0;
      o_wb_stall <= 1'b1;
      o_wb_ack   <= 1'b0;
      o_wb_err   <= 1'b0;
      o_wb_data  <= '0;
      o_leds     <= '0;
    end else begin
      o_wb_ack <= fin_ack && i_wb_cyc;
      o_wb_err <= fin_err && i_wb_cyc;
      if (fin_ack && fin_rd && i_wb_cyc) begin
        o_wb_data <= fin_data;
      end
      case (state)
        ST_INIT: begin
          mem[init_idx] <= DW'(init_idx);
          init_idx      <= init_idx + IW'(1);
          if (init_idx == IW'(DEPTH - 1)) begin
            state      <= ST_RUN;
            o_wb_stall <= 1'b0;
            o_leds[7]  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept && in_range) begin
            if (i_wb_we) begin
              for (int k = 0; k < SW; k++) begin
                if (i_wb_sel[k]) begin
                  mem[index][8*k +: 8] <= i_wb_data[8*k +: 8];
                end
              end
              o_leds[5:3] <= 3'(index);
            end else begin
              o_leds[2:0] <= 3'(index);
            end
          end
          if (req_err) begin
            o_leds[6] <= 1'b1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed bench for wb_mem_slave: three instances (LATENCY 1, LATENCY 3, LATENCY 4 with BASE_ADDR 16)
// share one request bus; each scenario task checks the instance(s) it targets.
module tb_wb_mem_slave;

  localparam int DW = 32;
  localparam int AW = 30;
`ifdef WB_MEM_SLAVE_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cyc = 1'b0;
  logic          stb = 1'b0;
  logic          we  = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    sel   = '0;

  logic          stall_a, ack_a, err_a;
  logic [DW-1:0] data_a;
  logic [7:0]    leds_a;
  logic          stall_b, ack_b, err_b;
  logic [DW-1:0] data_b;
  logic [7:0]    leds_b;
  logic          stall_c, ack_c, err_c;
  logic [DW-1:0] data_c;
  logic [7:0]    leds_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_mem_slave #(.LATENCY(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_stall(stall_a), .o_wb_ack(ack_a), .o_wb_err(err_a), .o_wb_data(data_a), .o_leds(leds_a)
  );

  wb_mem_slave #(.LATENCY(3)) u_b (
    .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_stall(stall_b), .o_wb_ack(ack_b), .o_wb_err(err_b), .o_wb_data(data_b), .o_leds(leds_b)
  );

  wb_mem_slave #(.LATENCY(4), .BASE_ADDR(16)) u_c (
    .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_stall(stall_c), .o_wb_ack(ack_c), .o_wb_err(err_c), .o_wb_data(data_c), .o_leds(leds_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    stb = 1'b0;
    we  = 1'b0;
    sel = '0;
  endtask

  task automatic req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    cyc   = 1'b1;
    stb   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    sel   = s;
  endtask

  // Called right after the last edge that sampled reset high; counts stall cycles from there.
  task automatic wait_run(output int n);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!stall_a) break;
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    cyc = 1'b0;
    idle_bus();
    step();
    step();
    n_tests++;
    if (ack_a !== 1'b0 || err_a !== 1'b0 || data_a !== '0 || leds_a !== 8'h00 || stall_a !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: ack=%b err=%b data=%h leds=%h stall=%b, required 0 0 0 00 1",
               ack_a, err_a, data_a, leds_a, stall_a);
    end
    rst = 1'b0;
    wait_run(n);
    n_tests++;
    if (n !== 8) begin
      n_fail++;
      $display("FAIL init_stall_cycles: got %0d, required 8", n);
    end
    n_tests++;
    if (leds_a !== 8'h80 || leds_c !== 8'h80) begin
      n_fail++;
      $display("FAIL leds_run: a=%h c=%h, required 80 80", leds_a, leds_c);
    end
  endtask

  task automatic test_init_contents();
    for (int i = 0; i < 8; i++) begin
      req(1'b0, AW'(i), '0, 4'hF);
      step();
      n_tests++;
      if (ack_a !== 1'b1 || data_a !== DW'(i)) begin
        n_fail++;
        $display("FAIL init_read[%0d]: ack=%b data=%h, required 1 %h", i, ack_a, data_a, DW'(i));
      end
    end
    idle_bus();
    step();
    n_tests++;
    if (ack_a !== 1'b0) begin
      n_fail++;
      $display("FAIL init_read_idle: ack=%b, required 0", ack_a);
    end
    repeat (3) step();
  endtask

  task automatic test_latency3();
    req(1'b1, 30'd2, 32'hDEADBEEF, 4'hF);
    step();
    n_tests++;
    if (ack_b !== 1'b0 || ack_a !== 1'b1) begin
      n_fail++;
      $display("FAIL lat3_s1: ack_b=%b ack_a=%b, required 0 1", ack_b, ack_a);
    end
    req(1'b0, 30'd2, '0, 4'hF);
    step();
    n_tests++;
    if (ack_b !== 1'b0 || ack_a !== 1'b1 || data_a !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL lat3_s2: ack_b=%b ack_a=%b data_a=%h, required 0 1 deadbeef", ack_b, ack_a, data_a);
    end
    idle_bus();
    step();
    n_tests++;
    if (ack_b !== 1'b1 || err_b !== 1'b0 || data_b !== 32'd7) begin
      n_fail++;
      $display("FAIL lat3_write_ack: ack=%b err=%b data=%h, required 1 0 00000007", ack_b, err_b, data_b);
    end
    step();
    n_tests++;
    if (ack_b !== 1'b1 || data_b !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL lat3_read_ack: ack=%b data=%h, required 1 deadbeef", ack_b, data_b);
    end
    step();
    n_tests++;
    if (ack_b !== 1'b0 || data_b !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL lat3_after: ack=%b data=%h, required 0 deadbeef", ack_b, data_b);
    end
  endtask

  task automatic test_byte_enable();
    req(1'b1, 30'd5, 32'hAABBCCDD, 4'b0101);
    step();
    req(1'b0, 30'd5, '0, 4'hF);
    step();
    n_tests++;
    if (ack_a !== 1'b1 || data_a !== 32'h00BB00DD) begin
      n_fail++;
      $display("FAIL byte_sel_read: ack=%b data=%h, required 1 00bb00dd", ack_a, data_a);
    end
    req(1'b1, 30'd6, 32'hFFFFFFFF, 4'b0000);
    step();
    n_tests++;
    if (ack_a !== 1'b1 || data_a !== 32'h00BB00DD) begin
      n_fail++;
      $display("FAIL sel0_write_ack: ack=%b data=%h, required 1 00bb00dd", ack_a, data_a);
    end
    req(1'b0, 30'd6, '0, 4'hF);
    step();
    n_tests++;
    if (ack_a !== 1'b1 || data_a !== 32'd6) begin
      n_fail++;
      $display("FAIL sel0_read: ack=%b data=%h, required 1 00000006", ack_a, data_a);
    end
    idle_bus();
    step();
    n_tests++;
    if (ack_a !== 1'b0 || leds_a !== 8'hB6) begin
      n_fail++;
      $display("FAIL leds_idx: ack=%b leds=%h, required 0 b6", ack_a, leds_a);
    end
    repeat (3) step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      req(1'b1, AW'(i), 32'hC0DE0000 | DW'(i), 4'hF);
      step();
      n_tests++;
      if (ack_a !== 1'b1 || err_a !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_write[%0d]: ack=%b err=%b, required 1 0", i, ack_a, err_a);
      end
    end
    for (int i = 0; i < 4; i++) begin
      req(1'b0, AW'(i), '0, 4'hF);
      step();
      n_tests++;
      if (ack_a !== 1'b1 || data_a !== (32'hC0DE0000 | DW'(i))) begin
        n_fail++;
        $display("FAIL b2b_read[%0d]: ack=%b data=%h, required 1 %h", i, ack_a, data_a, 32'hC0DE0000 | DW'(i));
      end
    end
    idle_bus();
    repeat (4) step();
  endtask

  task automatic test_err();
    int n;
    logic exp_ack, exp_err;
    rst = 1'b1;
    idle_bus();
    step();
    step();
    rst = 1'b0;
    wait_run(n);
    req(1'b0, 30'd17, '0, 4'hF);
    step();
    idle_bus();
    repeat (3) step();
    n_tests++;
    if (ack_c !== 1'b1 || data_c !== 32'd1) begin
      n_fail++;
      $display("FAIL err_pre_read: ack=%b data=%h, required 1 00000001", ack_c, data_c);
    end
    req(1'b0, 30'd24, '0, 4'hF);
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) idle_bus();
      exp_ack = (k == 3) && !ERR_ON;
      exp_err = (k == 3) && ERR_ON;
      n_tests++;
      if (ack_c !== exp_ack || err_c !== exp_err) begin
        n_fail++;
        $display("FAIL addr24_resp[%0d]: ack=%b err=%b, required %b %b", k, ack_c, err_c, exp_ack, exp_err);
      end
    end
    n_tests++;
    if (data_c !== (ERR_ON ? 32'd1 : 32'd0) || leds_c[6] !== ERR_ON) begin
      n_fail++;
      $display("FAIL addr24_after: data=%h led6=%b, required %h %b", data_c, leds_c[6],
               ERR_ON ? 32'd1 : 32'd0, ERR_ON);
    end
  endtask

  task automatic test_abort();
    req(1'b0, 30'd18, '0, 4'hF);
    step();
    req(1'b0, 30'd19, '0, 4'hF);
    step();
    cyc = 1'b0;
    idle_bus();
    for (int k = 0; k < 6; k++) begin
      step();
      n_tests++;
      if (ack_c !== 1'b0 || err_c !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet[%0d]: ack=%b err=%b, required 0 0", k, ack_c, err_c);
      end
    end
    n_tests++;
    if (data_c !== (ERR_ON ? 32'd1 : 32'd0)) begin
      n_fail++;
      $display("FAIL abort_data: data=%h, required %h", data_c, ERR_ON ? 32'd1 : 32'd0);
    end
    req(1'b0, 30'd19, '0, 4'hF);
    step();
    idle_bus();
    repeat (3) step();
    n_tests++;
    if (ack_c !== 1'b1 || err_c !== 1'b0 || data_c !== 32'd3) begin
      n_fail++;
      $display("FAIL abort_recover: ack=%b err=%b data=%h, required 1 0 00000003", ack_c, err_c, data_c);
    end
    repeat (2) step();
  endtask

  task automatic test_reset_mid_burst();
    int n;
    req(1'b1, 30'd3, 32'h00000055, 4'hF);
    step();
    req(1'b0, 30'd3, '0, 4'hF);
    step();
    n_tests++;
    if (ack_a !== 1'b1 || data_a !== 32'h55) begin
      n_fail++;
      $display("FAIL pre_reset_read: ack=%b data=%h, required 1 00000055", ack_a, data_a);
    end
    idle_bus();
    repeat (3) step();
    req(1'b0, 30'd0, '0, 4'hF);
    step();
    req(1'b0, 30'd1, '0, 4'hF);
    step();
    rst = 1'b1;
    req(1'b0, 30'd2, '0, 4'hF);
    step();
    n_tests++;
    if (ack_a !== 1'b0 || ack_b !== 1'b0 || ack_c !== 1'b0 || stall_a !== 1'b1 || data_a !== '0) begin
      n_fail++;
      $display("FAIL burst_reset: ack a/b/c=%b%b%b stall=%b data=%h, required 000 1 0",
               ack_a, ack_b, ack_c, stall_a, data_a);
    end
    req(1'b0, 30'd3, '0, 4'hF);
    step();
    rst = 1'b0;
    idle_bus();
    wait_run(n);
    n_tests++;
    if (n !== 8 || ack_b !== 1'b0 || ack_c !== 1'b0) begin
      n_fail++;
      $display("FAIL reinit: stall_cycles=%0d ack_b=%b ack_c=%b, required 8 0 0", n, ack_b, ack_c);
    end
    req(1'b0, 30'd3, '0, 4'hF);
    step();
    n_tests++;
    if (ack_a !== 1'b1 || data_a !== 32'd3) begin
      n_fail++;
      $display("FAIL reinit_read: ack=%b data=%h, required 1 00000003", ack_a, data_a);
    end
    idle_bus();
    step();
    n_tests++;
    if (leds_a !== 8'h83) begin
      n_fail++;
      $display("FAIL reinit_leds: leds=%h, required 83", leds_a);
    end
    step();
    n_tests++;
    if (ack_b !== 1'b1 || data_b !== 32'd3) begin
      n_fail++;
      $display("FAIL reinit_read_lat3: ack=%b data=%h, required 1 00000003", ack_b, data_b);
    end
  endtask

  initial begin
    test_reset();
    test_init_contents();
    test_latency3();
    test_byte_enable();
    test_back_to_back();
    test_err();
    test_abort();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_mem_slave.md
Name: wb_mem_slave

Overview:
- Parametrised pipelined Wishbone (B4 pipelined) memory slave for the wishboneV2 library.
- Provides DEPTH words of DW-bit storage with byte-select writes, configurable ack latency, an address-window decode and a post-reset initialisation sweep.
- Drives an 8-bit status/LED vector for board debug.
- Sits behind WB_master or the interconnect as a generic scratch/register memory.

Parameters:
- DW, 32, data width in bits; multiple of 8.
- AW, 30, word address width.
- DEPTH, 8, number of words; power of two, 2..256.
- BASE_ADDR, 0, word address of entry 0; aligned to DEPTH.
- LATENCY, 1, cycles from request acceptance to ack/err; 1..4.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_wb_cyc  in  1  bus cycle in progress
- i_wb_stb  in  1  request strobe
- i_wb_we  in  1  1 = write, 0 = read
- i_wb_addr  in  AW  word address
- i_wb_data  in  DW  write data
- i_wb_sel  in  DW/8  byte selects
- o_wb_stall  out  1  slave cannot accept request
- o_wb_ack  out  1  request completed OK
- o_wb_err  out  1  request completed with error
- o_wb_data  out  DW  read data, valid with ack
- o_leds  out  8  status vector

Behaviour:
- Reset values while i_rst = 1: o_wb_ack = 0, o_wb_err = 0, o_wb_data = 0, o_leds = 0, o_wb_stall = 1. Response pipeline is flushed. FSM goes to INIT with index = 0.
- INIT state: one word per cycle, mem[index] <= index (zero-extended to DW). o_wb_stall = 1. Done after DEPTH cycles, then RUN.
- Cycle timing: i_rst falls at edge E. The first request can be accepted at edge E+DEPTH+1.
- RUN state: o_wb_stall = 0. Request accepted at edge N when i_wb_cyc & i_wb_stb & !o_wb_stall.
- One request per cycle, no back-pressure.
- Requests presented while stall = 1 are not accepted and get no response.
- Decode (ERR_EN defined):
  - In range iff BASE_ADDR <= i_wb_addr < BASE_ADDR + DEPTH.
  - index = i_wb_addr - BASE_ADDR.
  - Out-of-range request: no memory access; completes with err instead of ack.
- Write, in range:
  - Committed at the acceptance edge.
  - Byte k is written iff i_wb_sel[k].
  - sel = 0 still acks with no change.
- Read, in range:
  - Full word captured at the acceptance edge, regardless of sel.
  - A read accepted the cycle after a write to the same index returns the new data.
- Response timing:
  - Request accepted at edge N gives a one-cycle ack or err pulse, visible after edge N+LATENCY-1.
  - LATENCY = 1 means registered outputs on the cycle after acceptance.
  - Back-to-back requests give back-to-back acks, in order.
  - ack and err are never high together.
- Read data: o_wb_data is updated only when a read ack is issued and holds otherwise. Write acks and err leave it unchanged.
- Abort: when i_wb_cyc = 0, all in-flight responses are dropped (ack/err suppressed), the pipeline is cleared, and writes already committed remain.
- Reset mid-RUN or mid-INIT: pending responses are lost, INIT restarts from index 0, and memory is reinitialised.
- o_leds:
  - [2:0] index[2:0] of the last accepted read.
  - [5:3] index[2:0] of the last accepted write.
  - [6] sticky, set on any err, cleared by reset.
  - [7] 1 in RUN.

Optional Feature:
- Macro WB_MEM_SLAVE_ERR_EN.
- Defined: window decode and err responses as above.
- Undefined:
  - No decode; index = i_wb_addr[log2(DEPTH)-1:0], so addresses alias modulo DEPTH.
  - Every accepted request acks.
  - o_wb_err is tied 0 and o_leds[6] = 0.

Test Plan:
- Reset release -> stall stays 1 for exactly DEPTH=8 cycles, o_leds[7] rises with stall fall. Reads of addr 0..7 return 0..7.
- LATENCY=3: write 0xDEADBEEF to addr 2 sel=4'b1111, then read addr 2 next cycle -> acks 3 cycles after each acceptance, consecutive; read data 0xDEADBEEF.
- Byte enables: write 0xAABBCCDD to addr 5 sel=4'b0101 over initial 0x00000005 -> read returns 0x00BB00DD.
- ERR_EN, BASE_ADDR=16: read addr 24 -> single err pulse, no ack, o_wb_data unchanged, o_leds[6]=1. Without macro, addr 24 aliases to index 0 -> ack, data 0.
- Abort: LATENCY=4, issue 2 reads, drop i_wb_cyc 2 cycles after the first -> no ack/err observed; next request acks normally.
- Reset asserted during a 4-request burst -> no further acks; INIT repeats; an addr-3 location previously written to 0x55 reads back 3.
